// File: rtl/spi_pkg.sv
// Shared definitions for the SPI main and its command sequencer: default
// bus widths, the sequencer state encoding and a counter-width helper.
// Define SIMULATION to shorten the default sequencer cooldown.
package spi_pkg;

  localparam int SPI_ADDR_WIDTH = 6;
  localparam int SPI_DATA_WIDTH = 8;

`ifdef SIMULATION
  localparam int SPI_SEQ_COOLDOWN_DEFAULT = 5;
`else
  localparam int SPI_SEQ_COOLDOWN_DEFAULT = 20;
`endif

  localparam int SPI_SEQ_TIMEOUT_DEFAULT = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_WAIT_DONE,
    S_RESP,
    S_COOLDOWN
  } spi_seq_state_t;

  // Bits needed to hold 0..n; never narrower than one bit so a zero-length
  // cooldown still yields a legal counter.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/spi_down_counter.sv
// Loadable down-counter that saturates at zero and never wraps.
// A load takes priority over a decrement in the same cycle.
module spi_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  // Count register: load, else decrement while non-zero.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Command front-end for the SPI main: takes one register read/write per
// handshake, drives the main's request inputs, detects completion from its
// chip-select, returns one response and then enforces a cooldown.
// Define SPI_SEQ_TIMEOUT_EN to build the watchdog that turns a stuck
// transaction into an error response.
module spi_cmd_sequencer
  import spi_pkg::*;
#(
  parameter int ADDR_WIDTH      = SPI_ADDR_WIDTH,
  parameter int DATA_WIDTH      = SPI_DATA_WIDTH,
  parameter int COOLDOWN_CYCLES = SPI_SEQ_COOLDOWN_DEFAULT,
  parameter int TIMEOUT_CYCLES  = SPI_SEQ_TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  spi_en,
  output logic                  spi_mode,
  output logic [ADDR_WIDTH-1:0] spi_addr,
  output logic [DATA_WIDTH-1:0] spi_wdata,
  output logic                  spi_write_valid,
  input  logic                  spi_cs,
  input  logic [DATA_WIDTH-1:0] spi_rdata,
  output logic                  busy
);

  localparam int CD_W = cnt_width(COOLDOWN_CYCLES);

  spi_seq_state_t        r_state, w_state_nxt;
  logic                  r_cmd_ready, w_cmd_ready_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic                  r_spi_en, w_spi_en_nxt;
  logic                  r_spi_mode, w_spi_mode_nxt;
  logic [ADDR_WIDTH-1:0] r_spi_addr, w_spi_addr_nxt;
  logic [DATA_WIDTH-1:0] r_spi_wdata, w_spi_wdata_nxt;
  logic                  r_spi_write_valid, w_spi_write_valid_nxt;
  logic                  r_busy, w_busy_nxt;

  logic                  w_cd_load, w_cd_dec, w_cd_zero;
  logic [CD_W-1:0]       w_cd_count;

  spi_down_counter #(.WIDTH(CD_W)) u_cooldown (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_cd_load),
    .i_load_val(CD_W'(COOLDOWN_CYCLES)),
    .i_dec     (w_cd_dec),
    .o_count   (w_cd_count),
    .o_zero    (w_cd_zero)
  );

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int WD_W = cnt_width(TIMEOUT_CYCLES);

  logic            r_rsp_error, w_rsp_error_nxt;
  logic            w_wd_load, w_wd_dec, w_wd_zero, w_wd_expire, w_in_wait;
  logic [WD_W-1:0] w_wd_count;

  // Watchdog: reloaded on acceptance, counts down while waiting on the main.
  spi_down_counter #(.WIDTH(WD_W)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_wd_load),
    .i_load_val(WD_W'(TIMEOUT_CYCLES)),
    .i_dec     (w_wd_dec),
    .o_count   (w_wd_count),
    .o_zero    (w_wd_zero)
  );

  assign w_in_wait   = (r_state == S_WAIT_START) || (r_state == S_WAIT_DONE);
  assign w_wd_dec    = w_in_wait;
  // Fires on the edge that completes the TIMEOUT_CYCLES-th waiting cycle.
  assign w_wd_expire = w_in_wait && (w_wd_zero || (w_wd_count == WD_W'(1)));
  assign rsp_error   = r_rsp_error;
`else
  assign rsp_error = 1'b0;
`endif

  // Next-state and next-output decode for the command/response sequence.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt           = r_state;
    w_cmd_ready_nxt       = r_cmd_ready;
    w_rsp_valid_nxt       = r_rsp_valid;
    w_rsp_rdata_nxt       = r_rsp_rdata;
    w_spi_en_nxt          = r_spi_en;
    w_spi_mode_nxt        = r_spi_mode;
    w_spi_addr_nxt        = r_spi_addr;
    w_spi_wdata_nxt       = r_spi_wdata;
    w_spi_write_valid_nxt = r_spi_write_valid;
    w_cd_load             = 1'b0;
    w_cd_dec              = 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
    w_rsp_error_nxt       = r_rsp_error;
    w_wd_load             = 1'b0;
`endif

    case (r_state)
      S_IDLE: begin
        w_cmd_ready_nxt = 1'b1;
        if (cmd_valid && r_cmd_ready) begin
          w_spi_mode_nxt        = cmd_write;
          w_spi_addr_nxt        = cmd_addr;
          w_spi_wdata_nxt       = cmd_wdata;
          w_spi_en_nxt          = 1'b1;
          w_spi_write_valid_nxt = cmd_write;
          w_cmd_ready_nxt       = 1'b0;
          w_state_nxt           = S_WAIT_START;
`ifdef SPI_SEQ_TIMEOUT_EN
          w_wd_load             = 1'b1;
`endif
        end
      end
      S_WAIT_START: begin
        // Chip-select falling means the main has taken the request.
        if (!spi_cs) begin
          w_spi_en_nxt          = 1'b0;
          w_spi_write_valid_nxt = 1'b0;
          w_state_nxt           = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        // Chip-select back high marks the end of the transfer.
        if (spi_cs) begin
          w_rsp_rdata_nxt = r_spi_mode ? '0 : spi_rdata;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_RESP;
`ifdef SPI_SEQ_TIMEOUT_EN
          w_rsp_error_nxt = 1'b0;
`endif
        end
      end
      S_RESP: begin
        if (r_rsp_valid && rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_cd_load       = 1'b1;
          if (COOLDOWN_CYCLES == 0) begin
            w_cmd_ready_nxt = 1'b1;
            w_state_nxt     = S_IDLE;
          end else begin
            w_state_nxt     = S_COOLDOWN;
          end
        end
      end
      S_COOLDOWN: begin
        w_cd_dec = 1'b1;
        if (w_cd_zero || (w_cd_count == CD_W'(1))) begin
          w_cmd_ready_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

`ifdef SPI_SEQ_TIMEOUT_EN
    // A stuck transaction is abandoned and reported as an error response.
    if (w_wd_expire) begin
      w_spi_en_nxt          = 1'b0;
      w_spi_write_valid_nxt = 1'b0;
      w_rsp_error_nxt       = 1'b1;
      w_rsp_rdata_nxt       = '0;
      w_rsp_valid_nxt       = 1'b1;
      w_state_nxt           = S_RESP;
    end
`endif

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers; reset drops any in-flight command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_cmd_ready       <= 1'b1;
      r_rsp_valid       <= 1'b0;
      r_rsp_rdata       <= '0;
      r_spi_en          <= 1'b0;
      r_spi_mode        <= 1'b0;
      r_spi_addr        <= '0;
      r_spi_wdata       <= '0;
      r_spi_write_valid <= 1'b0;
      r_busy            <= 1'b0;
    end else begin
      r_state           <= w_state_nxt;
      r_cmd_ready       <= w_cmd_ready_nxt;
      r_rsp_valid       <= w_rsp_valid_nxt;
      r_rsp_rdata       <= w_rsp_rdata_nxt;
      r_spi_en          <= w_spi_en_nxt;
      r_spi_mode        <= w_spi_mode_nxt;
      r_spi_addr        <= w_spi_addr_nxt;
      r_spi_wdata       <= w_spi_wdata_nxt;
      r_spi_write_valid <= w_spi_write_valid_nxt;
      r_busy            <= w_busy_nxt;
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  // Error flag register, present only with the watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_error <= 1'b0;
    end else begin
      r_rsp_error <= w_rsp_error_nxt;
    end
  end
`endif

  assign cmd_ready       = r_cmd_ready;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_rdata       = r_rsp_rdata;
  assign spi_en          = r_spi_en;
  assign spi_mode        = r_spi_mode;
  assign spi_addr        = r_spi_addr;
  assign spi_wdata       = r_spi_wdata;
  assign spi_write_valid = r_spi_write_valid;
  assign busy            = r_busy;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer with COOLDOWN_CYCLES=5 and
// TIMEOUT_CYCLES=16; the SPI main is played by driving spi_cs/spi_rdata.
// The watchdog scenario is compiled in when SPI_SEQ_TIMEOUT_EN is defined.
module tb_spi_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [5:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_error;
  logic [7:0] rsp_rdata;
  logic       spi_en, spi_mode, spi_write_valid, spi_cs, busy;
  logic [5:0] spi_addr;
  logic [7:0] spi_wdata, spi_rdata;

  int n_vec  = 0;
  int n_fail = 0;

  spi_cmd_sequencer #(
    .ADDR_WIDTH     (6),
    .DATA_WIDTH     (8),
    .COOLDOWN_CYCLES(5),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_error      (rsp_error),
    .spi_en         (spi_en),
    .spi_mode       (spi_mode),
    .spi_addr       (spi_addr),
    .spi_wdata      (spi_wdata),
    .spi_write_valid(spi_write_valid),
    .spi_cs         (spi_cs),
    .spi_rdata      (spi_rdata),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge; all driving and sampling
  // happens there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for the sequencer to offer cmd_ready again.
  task automatic wait_cmd_ready(input string tag);
    int n;
    n = 0;
    while (!cmd_ready && n < 40) begin
      tick();
      n++;
    end
    check(tag, cmd_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; rsp_ready = 1'b0; spi_cs = 1'b1; spi_rdata = '0;

    // Reset values
    tick(); tick();
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 8'h00);
    check("rst_rsp_error", rsp_error, 1'b0);
    check("rst_spi_en",    spi_en,    1'b0);
    check("rst_busy",      busy,      1'b0);
    check("rst_spi_addr",  spi_addr,  6'h00);
    rst = 1'b0;
    tick();

    // chip-select activity while idle is ignored
    spi_cs = 1'b0;
    tick(); tick();
    spi_cs = 1'b1;
    check("idle_cs_busy",  busy,      1'b0);
    check("idle_cs_ready", cmd_ready, 1'b1);
    check("idle_cs_en",    spi_en,    1'b0);

    // Read 0x2A, main returns 0xA5
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h2A; cmd_wdata = 8'h77;
    tick();                                   // edge T accepts
    cmd_valid = 1'b0;
    check("rd_en_t1",    spi_en,          1'b1);
    check("rd_mode_t1",  spi_mode,        1'b0);
    check("rd_addr_t1",  spi_addr,        6'h2A);
    check("rd_wv_t1",    spi_write_valid, 1'b0);
    check("rd_ready_t1", cmd_ready,       1'b0);
    check("rd_busy_t1",  busy,            1'b1);
    tick(); tick(); tick();                   // T+3: main drives cs low
    check("rd_en_t3", spi_en, 1'b1);
    spi_cs = 1'b0; spi_rdata = 8'hA5;
    tick();                                   // T+4: cs sampled low
    check("rd_en_t4",     spi_en,    1'b0);
    check("rd_rsp_early", rsp_valid, 1'b0);
    tick(); tick();
    spi_cs = 1'b1;
    check("rd_rsp_pre", rsp_valid, 1'b0);
    tick();
    check("rd_rsp_valid", rsp_valid, 1'b1);
    check("rd_rsp_rdata", rsp_rdata, 8'hA5);
    check("rd_rsp_error", rsp_error, 1'b0);

    // Accept response, then cmd_ready must reappear on the 6th cycle
    rsp_ready = 1'b1;
    tick();                                   // edge A: handshake
    check("rd_rsp_drop", rsp_valid, 1'b0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      check($sformatf("cd_ready_%0d", k + 1), cmd_ready, (k == 5) ? 1'b1 : 1'b0);
    end
    check("cd_busy_done", busy, 1'b0);

    // Write 0x05 <= 0x3C; rsp_ready already high
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h05; cmd_wdata = 8'h3C;
    tick();
    cmd_valid = 1'b0;
    check("wr_mode",  spi_mode,        1'b1);
    check("wr_addr",  spi_addr,        6'h05);
    check("wr_wdata", spi_wdata,       8'h3C);
    check("wr_wv_t1", spi_write_valid, 1'b1);
    tick(); tick(); tick();
    check("wr_wv_t3", spi_write_valid, 1'b1);
    spi_cs = 1'b0; spi_rdata = 8'hFF;
    tick();
    check("wr_wv_t4", spi_write_valid, 1'b0);
    check("wr_en_t4", spi_en,          1'b0);
    tick(); tick();
    spi_cs = 1'b1;
    tick();
    check("wr_rsp_valid", rsp_valid, 1'b1);
    check("wr_rsp_rdata", rsp_rdata, 8'h00);
    check("wr_rsp_error", rsp_error, 1'b0);
    tick();
    check("wr_rsp_one_cycle", rsp_valid, 1'b0);
    wait_cmd_ready("wr_ready_back");

    // Read 0x11 with the response held off for 10 cycles
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h11;
    tick();
    cmd_valid = 1'b0;
    tick(); tick(); tick();
    spi_cs = 1'b0; spi_rdata = 8'h5A;
    tick(); tick();
    spi_cs = 1'b1;
    tick();
    spi_rdata = 8'h00;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h3F; cmd_wdata = 8'h99;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("hold_valid_%0d", k), rsp_valid, 1'b1);
      check($sformatf("hold_rdata_%0d", k), rsp_rdata, 8'h5A);
      check($sformatf("hold_ready_%0d", k), cmd_ready, 1'b0);
      tick();
    end
    check("hold_spi_en",   spi_en,   1'b0);
    check("hold_spi_addr", spi_addr, 6'h11);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("hold_release", rsp_valid, 1'b0);
    wait_cmd_ready("hold_ready_back");

    // Reset while waiting for the main to start: spi_en falls at once
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h22;
    tick();
    cmd_valid = 1'b0;
    check("rst_ws_en_pre", spi_en, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_ws_en",    spi_en,    1'b0);
    check("rst_ws_ready", cmd_ready, 1'b1);
    #1;
    rst = 1'b0;

    // Reset while waiting for the transfer to finish: no response follows
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h22;
    tick();
    cmd_valid = 1'b0;
    tick(); tick(); tick();
    spi_cs = 1'b0;
    tick(); tick();
    check("rst_wd_busy_pre", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_wd_en",    spi_en,    1'b0);
    check("rst_wd_busy",  busy,      1'b0);
    check("rst_wd_ready", cmd_ready, 1'b1);
    check("rst_wd_addr",  spi_addr,  6'h00);
    #1;
    rst = 1'b0;
    spi_cs = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rst_no_rsp_%0d", k), rsp_valid, 1'b0);
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    // cs never falls: watchdog ends the command after 16 waiting cycles
    begin
      int n;
      rsp_ready = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h01; cmd_wdata = 8'hC3;
      tick();
      cmd_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 40) begin
        tick();
        n++;
      end
      check("to_cycles", n,         32'd16);
      check("to_valid",  rsp_valid, 1'b1);
      check("to_error",  rsp_error, 1'b1);
      check("to_rdata",  rsp_rdata, 8'h00);
      check("to_en",     spi_en,    1'b0);
      check("to_wv",     spi_write_valid, 1'b0);
      rsp_ready = 1'b1;
      tick();
      check("to_release", rsp_valid, 1'b0);
      wait_cmd_ready("to_ready_back");
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
